shift_feeder: RTL and testbench

Upstream serializer for `shift_reg`.
- Accepts one parallel word per valid/ready handshake.
- Replays it as `MSB` single-bit `d`/`en`/`dir` beats on the shift register's own input pins, so that the downstream register holds the word exactly after the last beat.
- Sits between a word-level producer and `shift_reg`; its `d`, `en` and `dir` outputs connect directly to the same-named `shift_reg` inputs.

---
 rtl/shift_feeder.sv | 181 ++++++++++++++++++
 tb/tb_shift_feeder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_feeder.sv
// ---------------------------------------------------------------------------
// shift_feeder
//
// Takes one parallel word per valid/ready handshake and replays it as a
// stream of single-bit beats on the d/en/dir pins of a downstream shift_reg.
// When the stream ends, the downstream register holds the word exactly. The
// beat order depends on the shift direction: MSB first when the downstream
// register shifts left, LSB first when it shifts right.
//
// Optional feature macro: SHIFT_FEEDER_PARITY_EN
//   When it is defined, one extra even-parity beat (d = ^word) follows the
//   last data beat. This suits a downstream register of width MSB+1.
//   When it is undefined, exactly MSB beats are sent and no parity logic is
//   built.
//
// Parameters:
//   MSB       word width (>= 2); must match the downstream shift_reg width
//
// Ports:
//   clk       in   single clock, all state updates on posedge
//   rstn      in   asynchronous active-low reset
//   in_data   in   [MSB-1:0] word to serialize, sampled on handshake only
//   in_dir    in   0 = downstream shifts left, 1 = downstream shifts right
//   in_valid  in   producer has a word
//   in_ready  out  registered, block can accept a word (IDLE only)
//   d         out  registered serial bit, 0 whenever en is 0
//   en        out  registered shift enable, high once per beat
//   dir       out  registered direction, held for the whole word and while idle
//   busy      out  high while a word is being shifted or completed
//   done      out  one-cycle pulse after the last beat
// ---------------------------------------------------------------------------
module shift_feeder #(
  parameter int MSB = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [MSB-1:0] in_data,
  input  logic           in_dir,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           d,
  output logic           en,
  output logic           dir,
  output logic           busy,
  output logic           done
);

  // The counter must be able to reach MSB so that it can tag the parity beat.
  localparam int CW = $clog2(MSB + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [MSB-1:0]  r_word;
  logic            r_dir;
  logic [CW-1:0]   r_cnt;
  logic            r_d;
  logic            r_en;
  logic            r_done;
  logic            r_inReady;

  state_t          w_stateNext;
  logic [MSB-1:0]  w_wordNext;
  logic            w_dirNext;
  logic [CW-1:0]   w_cntNext;
  logic            w_dNext;
  logic            w_enNext;
  logic            w_doneNext;
  logic            w_inReadyNext;
  logic [CW-1:0]   w_cntInc;
  logic [CW-1:0]   w_shiftAmt;
  logic            w_dataBit;

  // Next-state and next-output logic. Every output is registered, so this
  // block computes the value each output pin shows after the coming edge.
  // The beat for counter value k goes out when r_cnt becomes k. So the bit
  // selected here is the one for r_cnt+1. The exception is the first beat,
  // which is taken directly from in_data on the handshake edge.
  always_comb begin
    w_stateNext = r_state;
    w_wordNext  = r_word;
    w_dirNext   = r_dir;
    w_cntNext   = r_cnt;
    w_dNext     = 1'b0;
    w_enNext    = 1'b0;
    w_doneNext  = 1'b0;

    // Bit position of the next data beat. The bit is picked out with a
    // shifted one-hot mask, so the index can be wider than log2(MSB).
    w_cntInc   = r_cnt + CW'(1);
    w_shiftAmt = r_dir ? w_cntInc : (CW'(MSB - 1) - w_cntInc);
    w_dataBit  = |(r_word & (MSB'(1) << w_shiftAmt));

    case (r_state)
      IDLE: begin
        if (in_valid && r_inReady) begin
          w_stateNext = SHIFT;
          w_wordNext  = in_data;
          w_dirNext   = in_dir;
          w_cntNext   = '0;
          w_enNext    = 1'b1;
          w_dNext     = in_dir ? in_data[0] : in_data[MSB-1];
        end
      end

      SHIFT: begin
`ifdef SHIFT_FEEDER_PARITY_EN
        if (r_cnt == CW'(MSB)) begin
          w_stateNext = DONE;
          w_doneNext  = 1'b1;
        end else if (r_cnt == CW'(MSB - 1)) begin
          w_cntNext = w_cntInc;
          w_enNext  = 1'b1;
          w_dNext   = ^r_word;
        end else begin
          w_cntNext = w_cntInc;
          w_enNext  = 1'b1;
          w_dNext   = w_dataBit;
        end
`else
        if (r_cnt == CW'(MSB - 1)) begin
          w_stateNext = DONE;
          w_doneNext  = 1'b1;
        end else begin
          w_cntNext = w_cntInc;
          w_enNext  = 1'b1;
          w_dNext   = w_dataBit;
        end
`endif
      end

      DONE: begin
        w_stateNext = IDLE;
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase

    // in_ready is the registered form of "we will be idle after this edge".
    // As a result it first rises one edge after reset is released.
    w_inReadyNext = (w_stateNext == IDLE);
  end

  // State and output registers. Reset puts every output in its quiet state
  // at once and discards any word that was in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_word    <= '0;
      r_dir     <= 1'b0;
      r_cnt     <= '0;
      r_d       <= 1'b0;
      r_en      <= 1'b0;
      r_done    <= 1'b0;
      r_inReady <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_word    <= w_wordNext;
      r_dir     <= w_dirNext;
      r_cnt     <= w_cntNext;
      r_d       <= w_dNext;
      r_en      <= w_enNext;
      r_done    <= w_doneNext;
      r_inReady <= w_inReadyNext;
    end
  end

  assign in_ready = r_inReady;
  assign d        = r_d;
  assign en       = r_en;
  assign dir      = r_dir;
  assign done     = r_done;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_shift_feeder.sv
// ---------------------------------------------------------------------------
// tb_shift_feeder
//
// Directed bench for shift_feeder. It includes a queue-based behavioural
// model of the expected pin activity and a downstream shift register model
// fed by the DUT pins. Build with +define+SHIFT_FEEDER_PARITY_EN to exercise
// the parity-beat variant.
// ---------------------------------------------------------------------------
module tb_shift_feeder;

  localparam int MSB = 8;
`ifdef SHIFT_FEEDER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int W = MSB + PAR;

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic [MSB-1:0] in_data = '0;
  logic           in_dir = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           d;
  logic           en;
  logic           dir;
  logic           busy;
  logic           done;

  int total = 0;
  int bad = 0;

  shift_feeder #(.MSB(MSB)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_data  (in_data),
    .in_dir   (in_dir),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d        (d),
    .en       (en),
    .dir      (dir),
    .busy     (busy),
    .done     (done)
  );

  // 10-time-unit clock
  always #5 clk = ~clk;

  // Cycle counter, stepped on every active edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream shift_reg stand-in: dir 0 shifts left with the bit entering
  // at the LSB; dir 1 shifts right with the bit entering at the MSB.
  logic [W-1:0] shreg = '0;
  always @(posedge clk) begin
    if (en) begin
      if (dir) shreg <= {d, shreg[W-1:1]};
      else     shreg <= {shreg[W-2:0], d};
    end
  end

  // Behavioural model. A handshake turns the word into a per-cycle schedule
  // of pin values; each edge plays one entry. When the schedule is empty
  // the block is idle and ready.
  typedef struct packed {
    logic en;
    logic d;
    logic done;
  } rec_t;

  rec_t           sched[$];
  logic           mReady = 1'b0;
  logic           mEn = 1'b0;
  logic           mD = 1'b0;
  logic           mDir = 1'b0;
  logic           mBusy = 1'b0;
  logic           mDone = 1'b0;
  logic [MSB-1:0] mWord = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sched.delete();
      mReady <= 1'b0;
      mEn    <= 1'b0;
      mD     <= 1'b0;
      mDir   <= 1'b0;
      mBusy  <= 1'b0;
      mDone  <= 1'b0;
    end else begin
      if (mReady && in_valid) begin
        for (int i = 0; i < MSB; i++)
          sched.push_back(rec_t'{1'b1, (in_dir ? in_data[i] : in_data[MSB-1-i]), 1'b0});
        if (PAR == 1)
          sched.push_back(rec_t'{1'b1, ^in_data, 1'b0});
        sched.push_back(rec_t'{1'b0, 1'b0, 1'b1});
        mWord <= in_data;
        mDir  <= in_dir;
      end
      if (sched.size() != 0) begin
        mEn    <= sched[0].en;
        mD     <= sched[0].d;
        mDone  <= sched[0].done;
        mBusy  <= 1'b1;
        mReady <= 1'b0;
        sched.delete(0);
      end else begin
        mEn    <= 1'b0;
        mD     <= 1'b0;
        mDone  <= 1'b0;
        mBusy  <= 1'b0;
        mReady <= 1'b1;
      end
    end
  end

  // Register contents that a full word must leave downstream
  function automatic logic [W-1:0] expShreg(input logic [MSB-1:0] w, input logic dr);
    logic [W-1:0] r;
`ifdef SHIFT_FEEDER_PARITY_EN
    r = dr ? {^w, w} : {w, ^w};
`else
    r = w;
    if (dr) r = w;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: on every falling edge it checks all outputs against
  // the model. It also records the beat stream and snapshots the result
  // on each done pulse.
  logic        checkOn = 1'b0;
  logic [15:0] seq = '0;
  int          beatCnt = 0;
  int          enSeen = 0;
  int          doneCount = 0;
  logic [15:0] capSeq = '0;
  int          capBeats = 0;
  int          capCyc = 0;
  logic [W-1:0] capShreg = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (checkOn) begin
        checkOutput("in_ready", 32'(in_ready), 32'(mReady));
        checkOutput("en", 32'(en), 32'(mEn));
        checkOutput("d", 32'(d), 32'(mD));
        checkOutput("dir", 32'(dir), 32'(mDir));
        checkOutput("busy", 32'(busy), 32'(mBusy));
        checkOutput("done", 32'(done), 32'(mDone));
        if (!rstn) begin
          seq = '0;
          beatCnt = 0;
        end else begin
          if (en) begin
            seq = {seq[14:0], d};
            beatCnt++;
            enSeen++;
          end
          if (done) begin
            doneCount++;
            capSeq = seq;
            capBeats = beatCnt;
            capCyc = cyc;
            capShreg = shreg;
            checkOutput("shreg_vs_model", 32'(shreg), 32'(expShreg(mWord, mDir)));
            seq = '0;
            beatCnt = 0;
          end
        end
      end
    end
  end

  // Present a word and wait (bounded) for it to be taken. hs returns the
  // cycle number of the accepting edge. When keep is set, in_valid stays
  // high after acceptance.
  task automatic applyStimulus(input logic [MSB-1:0] word, input logic dr,
                               input logic keep, output int hs);
    int waited;
    in_data  = word;
    in_dir   = dr;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("handshake_timeout", 32'(in_ready), 32'd1);
      hs = 0;
    end else begin
      hs = cyc + 1;
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  // Bounded wait until the compare process has seen one more done pulse
  task automatic waitDone(input int startCount);
    int waited;
    waited = 0;
    while (doneCount == startCount && waited < 60) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("done_seen", 32'(doneCount), 32'(startCount + 1));
  endtask

  // Watchdog in case anything stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int hs1;
    int hs2;
    int dc;
    int enBefore;

    $display("[TB] starting, MSB=%0d parity=%0d", MSB, PAR);

    // Asynchronous reset: outputs must be quiet before any clock edge
    #2 rstn = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_en", 32'(en), 32'd0);
    checkOutput("rst_d", 32'(d), 32'd0);
    checkOutput("rst_dir", 32'(dir), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
    checkOn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

    // A5 with dir 0: MSB first, beats 1,0,1,0,0,1,0,1
    dc = doneCount;
    applyStimulus(8'hA5, 1'b0, 1'b0, hs1);
    waitDone(dc);
    checkOutput("A5_seq", 32'(capSeq), (PAR == 1) ? 32'h14A : 32'hA5);
    checkOutput("A5_beats", 32'(capBeats), 32'(MSB + PAR));
    checkOutput("A5_done_latency", 32'(capCyc - hs1), 32'(MSB + PAR));
    checkOutput("A5_shreg", 32'(capShreg), (PAR == 1) ? 32'h14A : 32'hA5);

    // 3C with dir 1: LSB first, beats 0,0,1,1,1,1,0,0
    dc = doneCount;
    applyStimulus(8'h3C, 1'b1, 1'b0, hs1);
    waitDone(dc);
    checkOutput("3C_seq", 32'(capSeq), (PAR == 1) ? 32'h078 : 32'h3C);
    checkOutput("3C_dir", 32'(dir), 32'd1);
    checkOutput("3C_shreg", 32'(capShreg), 32'h3C);

    // Back-to-back with in_valid held high through SHIFT and DONE
    dc = doneCount;
    applyStimulus(8'hFF, 1'b0, 1'b1, hs1);
    applyStimulus(8'h01, 1'b0, 1'b0, hs2);
    checkOutput("b2b_spacing", 32'(hs2 - hs1), 32'(MSB + 2 + PAR));
    waitDone(dc + 1);
    checkOutput("b2b_shreg", 32'(capShreg), (PAR == 1) ? 32'h003 : 32'h01);

`ifdef SHIFT_FEEDER_PARITY_EN
    // 07 with dir 0: eight data beats plus a parity beat of 1
    dc = doneCount;
    applyStimulus(8'h07, 1'b0, 1'b0, hs1);
    waitDone(dc);
    checkOutput("par_beats", 32'(capBeats), 32'd9);
    checkOutput("par_seq", 32'(capSeq), 32'h00F);
    checkOutput("par_last_bit", 32'(capSeq[0]), 32'd1);
    checkOutput("par_done_latency", 32'(capCyc - hs1), 32'd9);
`endif

    // Reset during the 4th beat of 5A with dir 1 (LSB first: 0,1,0,1,...)
    applyStimulus(8'h5A, 1'b1, 1'b0, hs1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3;
    checkOutput("beat4_en", 32'(en), 32'd1);
    checkOutput("beat4_d", 32'(d), 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst_en", 32'(en), 32'd0);
    checkOutput("midrst_d", 32'(d), 32'd0);
    checkOutput("midrst_dir", 32'(dir), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_midrst", 32'(in_ready), 32'd1);
    enBefore = enSeen;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("no_residual_en", 32'(enSeen - enBefore), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
